// File: rtl/sprite_pkg.sv
// sprite_pkg: command word layout, reserved codes and sequencer states
package sprite_pkg;
  localparam int COMP_MSB = 31;
  localparam int COMP_LSB = 26;
  localparam int ACT_MSB = 20;
  localparam int ACT_LSB = 17;
  localparam int BUF_BIT = 13;
  localparam logic [5:0] COMP_IDLE = 6'd0;
  localparam logic [3:0] ACT_UPDATE = 4'h1;
  localparam logic [3:0] ACT_SWAP = 4'hF;
  localparam logic [31:0] CMD_COMMIT = 32'h001E0000;
  typedef enum logic [1:0] {IDLE, WAIT_VBLANK, SWAP, FLIP} seq_state_t;
  function automatic logic is_commit(input logic [31:0] w);
    return w[COMP_MSB:COMP_LSB] == COMP_IDLE && w[ACT_MSB:ACT_LSB] == ACT_SWAP;
  endfunction
  function automatic logic [31:0] restamp(input logic [31:0] w, input logic b);
    logic [31:0] r;
    r = w;
    if (w[ACT_MSB:ACT_LSB] == ACT_UPDATE) r[BUF_BIT] = b;
    return r;
  endfunction
  function automatic logic [31:0] swap_word(input logic [5:0] id, input logic b);
    logic [31:0] r;
    r = '0;
    r[COMP_MSB:COMP_LSB] = id;
    r[ACT_MSB:ACT_LSB] = ACT_SWAP;
    r[BUF_BIT] = b;
    return r;
  endfunction
endpackage

// File: rtl/sprite_frame_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with first-word-visible head
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/sprite_frame_sequencer.sv
// sprite_frame_sequencer: queues sprite commands and issues vblank-aligned buffer swaps
module sprite_frame_sequencer
  import sprite_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_COMPONENTS = 16,
  parameter int VBLANK_START = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [31:0]                   cmd_data,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  output logic [31:0]                   sprite_writedata,
  output logic                          back_buffer,
  output logic [15:0]                   frame_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  seq_state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [31:0] out_q, out_d;
  logic back_q, back_d;
  logic [15:0] frame_q, frame_d;
  logic overflow_q, overflow_d;
  logic full, empty, pop;
  logic [31:0] head;
  logic unused_hcount;
  assign unused_hcount = ^hcount;
  assign cmd_ready = !full;
  assign sprite_writedata = out_q;
  assign back_buffer = back_q;
  assign frame_count = frame_q;
  assign overflow = overflow_q;
  cmd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(cmd_valid && !full), .pop(pop),
    .din(cmd_data), .dout(head), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    out_d = '0;
    back_d = back_q;
    frame_d = frame_q;
    pop = 1'b0;
    overflow_d = overflow_q || (cmd_valid && full);
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_d = is_commit(head) ? WAIT_VBLANK : IDLE;
        out_d = is_commit(head) ? '0 : restamp(head, back_q);
      end
      WAIT_VBLANK: if (vcount >= 10'(VBLANK_START)) begin
        state_d = SWAP;
        idx_d = 6'd1;
      end
      SWAP: begin
        out_d = swap_word(idx_q, back_q);
        idx_d = idx_q + 6'd1;
        state_d = idx_q == 6'(NUM_COMPONENTS) ? FLIP : SWAP;
      end
      FLIP: begin
        back_d = !back_q;
        frame_d = frame_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      out_q <= '0;
      back_q <= 1'b1;
      frame_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      out_q <= out_d;
      back_q <= back_d;
      frame_q <= frame_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// tb_sprite_frame_sequencer: directed checks of queueing, restamping, swap bursts and reset
module tb_sprite_frame_sequencer;
  localparam logic [31:0] COMMIT = 32'h001E0000;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready;
  logic [31:0] cmd_data = 0, sprite_writedata;
  logic [9:0] hcount = 0, vcount = 100;
  logic back_buffer, overflow;
  logic [15:0] frame_count;
  logic [4:0] fifo_level;
  int checks = 0, failures = 0;
  logic exp_back = 1'b1;
  logic [15:0] exp_frame = 16'd0;

  sprite_frame_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .hcount(hcount), .vcount(vcount),
    .sprite_writedata(sprite_writedata), .back_buffer(back_buffer),
    .frame_count(frame_count), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) hcount <= hcount + 10'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd_valid = 1;
    cmd_data = w;
    tick();
    cmd_valid = 0;
    cmd_data = 0;
  endtask

  function automatic logic [31:0] swp(input int i, input logic b);
    return (32'(i) << 26) | 32'h001E0000 | (b ? 32'h2000 : 32'h0);
  endfunction

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", sprite_writedata); end
    checks++; if (back_buffer !== 1'b1) begin failures++; $display("FAIL reset_back got=%b exp=1", back_buffer); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame got=%0d exp=0", frame_count); end
    checks++; if (fifo_level !== 5'd0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_fifo level=%0d ready=%b exp 0/1", fifo_level, cmd_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_update();
    vcount = 100;
    push(32'h24028064);
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL update_early got=%h exp=0", sprite_writedata); end
    tick();
    checks++; if (sprite_writedata !== 32'h2402A064) begin failures++; $display("FAIL update_word got=%h exp=2402a064", sprite_writedata); end
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL update_idle got=%h exp=0", sprite_writedata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 32'h14040000 | 32'(i + 1);
    for (int i = 0; i < 4; i++) begin
      push(w[i]);
      if (i > 0) begin
        checks++; if (sprite_writedata !== w[i-1]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, sprite_writedata, w[i-1]); end
      end
      if (i == 2) begin
        checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL b2b_level got=%0d exp=1", fifo_level); end
      end
    end
    tick();
    checks++; if (sprite_writedata !== w[3]) begin failures++; $display("FAIL b2b_last got=%h exp=%h", sprite_writedata, w[3]); end
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL b2b_idle got=%h exp=0", sprite_writedata); end
  endtask

  task automatic test_commit();
    int nz;
    vcount = 100;
    push(32'h24028064);
    push(COMMIT);
    checks++; if (sprite_writedata !== 32'h2402A064) begin failures++; $display("FAIL commit_first got=%h exp=2402a064", sprite_writedata); end
    push(32'h2802A064);
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      if (sprite_writedata !== 32'h0) nz++;
      tick();
    end
    checks++; if (nz != 0) begin failures++; $display("FAIL commit_stall nonidle=%0d exp=0", nz); end
    checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL commit_level got=%0d exp=1", fifo_level); end
    vcount = 480;
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL commit_pre_swap got=%h exp=0", sprite_writedata); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (sprite_writedata !== swp(i, 1'b1)) begin failures++; $display("FAIL swap_word%0d got=%h exp=%h", i, sprite_writedata, swp(i, 1'b1)); end
    end
    vcount = 100;
    tick();
    exp_back = 1'b0;
    exp_frame = 16'd1;
    checks++; if (sprite_writedata !== 32'h0 || back_buffer !== 1'b0 || frame_count !== 16'd1) begin failures++; $display("FAIL commit_flip out=%h back=%b frame=%0d exp 0/0/1", sprite_writedata, back_buffer, frame_count); end
    tick();
    checks++; if (sprite_writedata !== 32'h28028064) begin failures++; $display("FAIL commit_third got=%h exp=28028064", sprite_writedata); end
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL commit_idle got=%h exp=0", sprite_writedata); end
  endtask

  task automatic test_overflow();
    int nw, nbad;
    logic [31:0] last;
    vcount = 100;
    push(COMMIT);
    for (int i = 1; i <= 16; i++) push(32'h14040000 | 32'(i));
    checks++; if (cmd_ready !== 1'b0 || fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_full ready=%b level=%0d exp 0/16", cmd_ready, fifo_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    push(32'h14040011);
    checks++; if (overflow !== 1'b1 || fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_set ovf=%b level=%0d exp 1/16", overflow, fifo_level); end
    vcount = 480;
    nw = 0;
    nbad = 0;
    last = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sprite_writedata[31:16] == 16'h1404) begin nw++; last = sprite_writedata; end
      if (sprite_writedata == 32'h14040011) nbad++;
    end
    vcount = 100;
    exp_back = ~exp_back;
    exp_frame++;
    checks++; if (nw != 16 || nbad != 0) begin failures++; $display("FAIL ovf_drain words=%0d dropped_seen=%0d exp 16/0", nw, nbad); end
    checks++; if (last !== 32'h14040010) begin failures++; $display("FAIL ovf_last got=%h exp=14040010", last); end
    checks++; if (fifo_level !== 5'd0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_after level=%0d ovf=%b exp 0/1", fifo_level, overflow); end
    checks++; if (frame_count !== exp_frame || back_buffer !== exp_back) begin failures++; $display("FAIL ovf_frame frame=%0d back=%b exp %0d/%b", frame_count, back_buffer, exp_frame, exp_back); end
  endtask

  task automatic test_vblank_commit();
    vcount = 500;
    push(COMMIT);
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL vb_wait1 got=%h exp=0", sprite_writedata); end
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL vb_wait2 got=%h exp=0", sprite_writedata); end
    tick();
    checks++; if (sprite_writedata !== swp(1, exp_back)) begin failures++; $display("FAIL vb_first got=%h exp=%h", sprite_writedata, swp(1, exp_back)); end
    for (int i = 0; i < 20; i++) tick();
    exp_back = ~exp_back;
    exp_frame++;
    checks++; if (frame_count !== exp_frame || back_buffer !== exp_back) begin failures++; $display("FAIL vb_frame frame=%0d back=%b exp %0d/%b", frame_count, back_buffer, exp_frame, exp_back); end
  endtask

  task automatic test_frames();
    vcount = 480;
    for (int f = 0; f < 4; f++) begin
      push(COMMIT);
      for (int k = 0; k < 40 && frame_count === exp_frame; k++) tick();
      exp_back = ~exp_back;
      exp_frame++;
      checks++; if (frame_count !== exp_frame || back_buffer !== exp_back || sprite_writedata !== 32'h0) begin failures++; $display("FAIL frames_%0d frame=%0d back=%b out=%h exp %0d/%b/0", f, frame_count, back_buffer, sprite_writedata, exp_frame, exp_back); end
    end
    vcount = 100;
  endtask

  task automatic test_reset_mid_swap();
    vcount = 500;
    push(COMMIT);
    push(32'h24028064);
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (sprite_writedata !== swp(5, exp_back) || fifo_level !== 5'd1) begin failures++; $display("FAIL rst_swap5 out=%h level=%0d exp %h/1", sprite_writedata, fifo_level, swp(5, exp_back)); end
    reset = 1;
    tick();
    exp_back = 1'b1;
    exp_frame = 16'd0;
    checks++; if (sprite_writedata !== 32'h0 || back_buffer !== 1'b1 || fifo_level !== 5'd0 || frame_count !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_mid out=%h back=%b level=%0d frame=%0d ovf=%b exp 0/1/0/0/0", sprite_writedata, back_buffer, fifo_level, frame_count, overflow); end
    tick();
    checks++; if (sprite_writedata !== 32'h0) begin failures++; $display("FAIL rst_hold got=%h exp=0", sprite_writedata); end
    reset = 0;
    vcount = 100;
    push(32'h24028064);
    tick();
    checks++; if (sprite_writedata !== 32'h2402A064) begin failures++; $display("FAIL rst_idle_state got=%h exp=2402a064", sprite_writedata); end
  endtask

  initial begin
    test_reset();
    test_update();
    test_back_to_back();
    test_commit();
    test_overflow();
    test_vblank_commit();
    test_frames();
    test_reset_mid_swap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
